wdt_servicer: RTL
=================

# wdt_servicer

Watchdog servicing block on the supervised side of the watchdog interface. It issues the periodic clear pulse (`o_clrwdt`) that keeps the watchdog timer from expiring, but only while the supervised logic proves it is alive through a heartbeat strobe. It deliberately withholds the kick when the heartbeat stops, then tracks the watchdog's hardware-reset response and re-arms after the reset is released. It sits between the CPU/software heartbeat source and the watchdog timer's `i_clrwdt`, `o_fail_safe` and `o_hardware_rst` pins.

## Interface
Parameters:
- `CNT_W`, 32: width of the kick-period counter and of the kick counter.
- `RST_CNT_W`, 8: width of the hardware-reset event counter.

Ports:
- `i_clk`  in  1  single clock for the block.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_enable`  in  1  servicing enable; low forces IDLE.
- `i_kick_period`  in  CNT_W  reload value; kick interval = `i_kick_period`+1 cycles.
- `i_heartbeat`  in  1  liveness strobe from supervised logic, any width.
- `i_fail_safe`  in  1  watchdog fail-safe indication.
- `i_hardware_rst`  in  1  watchdog hardware-reset indication.
- `o_clrwdt`  out  1  one-cycle watchdog clear pulse.
- `o_state`  out  2  IDLE=0, ARMED=1, STARVED=2, RESET_HOLD=3.
- `o_starved`  out  1  high while in STARVED.
- `o_fail_seen`  out  1  sticky: `i_fail_safe` sampled high since reset.
- `o_kick_count`  out  CNT_W  kicks issued, wraps modulo 2^CNT_W.
- `o_rst_count`  out  RST_CNT_W  hardware resets observed, saturates at all-ones.

## Operation
- All outputs are registered. Reset (`i_rst_n`=0) forces: state IDLE, `o_clrwdt`=0, `o_starved`=0, `o_fail_seen`=0, `o_kick_count`=0, `o_rst_count`=0, internal counter=0, heartbeat flag=0.
- Priority per edge: `i_hardware_rst` > `i_enable` low > state behaviour.
- Any state except RESET_HOLD, `i_hardware_rst`=1: go to RESET_HOLD, `o_rst_count`++ (saturating), no kick.
- IDLE: with `i_enable`=1, issue the initial kick (`o_clrwdt`=1, `o_kick_count`++), load counter from `i_kick_period`, clear the heartbeat flag, and go to ARMED.
- ARMED: set the heartbeat flag on `i_heartbeat`=1. While counter≠0, decrement it. At counter=0:
  - If the flag is set, or `i_heartbeat`=1 in that same cycle: kick, reload the counter, clear the flag.
  - Otherwise: go to STARVED with no kick.
- STARVED: no kicks. A late `i_heartbeat` does not recover the block; only watchdog reset or `i_enable` low exits.
- RESET_HOLD: `i_enable` is ignored. No kicks. When `i_hardware_rst`=0, go to IDLE. If `i_enable` is still high, IDLE re-arms on the following edge.
- `i_enable`=0 in ARMED or STARVED: go to IDLE on that edge, clearing the counter and the flag.
- `o_fail_seen` is set on any edge with `i_fail_safe`=1 and is cleared only by reset.
- `i_kick_period` is sampled only at load/reload. Mid-period changes take effect at the next reload.

## Timing
- `o_clrwdt` is exactly one cycle wide and never asserted on two consecutive cycles unless `i_kick_period`=0. With `i_kick_period`=0 and a continuous heartbeat, the block kicks every cycle.
- Initial kick: `o_clrwdt` high in the cycle after the edge that sampled `i_enable`=1 in IDLE.
- In steady ARMED state, kicks are spaced `i_kick_period`+1 cycles apart.
- Starvation: `o_starved` rises `i_kick_period`+1 cycles after the last kick when no heartbeat arrived in that window.
- A heartbeat on the same edge as counter=0 counts for the current window.
- `i_hardware_rst` to RESET_HOLD takes one edge. Release to IDLE takes one edge, and the re-arm kick comes on the next edge. Recovery therefore takes 2 cycles from release to kick.
- Asserting `i_rst_n` mid-pulse drops `o_clrwdt` immediately (asynchronous).

## Test plan
- **Reset, then steady heartbeat.** Reset, then `i_enable`=1, `i_kick_period`=4, `i_heartbeat` pulsed every 3 cycles. Required: first kick one cycle after enable, then kicks every 5 cycles; after 4 kicks `o_kick_count`=4; `o_state`=1 throughout.
- **Heartbeat stops.** `i_kick_period`=9, heartbeat stops after kick #2. Required: `o_starved`=1 and `o_state`=2 10 cycles after kick #2; no further kicks. A late heartbeat leaves the state at 2.
- **Watchdog reset cycle.** From STARVED, assert `i_fail_safe` for 3 cycles, then `i_hardware_rst` for 6 cycles. Required:
  - `o_fail_seen`=1;
  - `o_state`=3 one cycle after reset assert, `o_rst_count`=1;
  - IDLE one cycle after release, then a kick and ARMED the next cycle.
- **Same-edge heartbeat and reset during ARMED.** `i_heartbeat` exactly on the counter=0 cycle with `i_kick_period`=2. Required: kick issued. Separately, `i_hardware_rst`=1 while ARMED: RESET_HOLD with no kick, even if the counter hits 0 on that edge.
- **Enable drop.** `i_enable`=0 in ARMED with counter=3. Required: IDLE next cycle, no kick. Re-enable: immediate kick, full period reload.
- **Counter limits and async reset.**
  - With `RST_CNT_W`=2, force 5 hardware-reset events: `o_rst_count` stays at 3.
  - Preload the kick count to 2^CNT_W−1 and kick once: it wraps to 0.
  - Assert `i_rst_n` mid-kick: all outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/wdt_servicer.sv
// -----------------------------------------------------------------------------
// wdt_servicer
//
// Supervised-side watchdog servicer. Periodically pulses o_clrwdt to keep an
// external watchdog timer from expiring, but only while the supervised logic
// keeps strobing i_heartbeat. If a whole kick window passes without a
// heartbeat, the kick is withheld on purpose so the watchdog can fire. The
// block then follows the watchdog's hardware-reset indication and re-arms
// after that reset is released.
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_enable        servicing enable; low returns the block to IDLE
//   i_kick_period   reload value; kick interval is i_kick_period+1 cycles
//   i_heartbeat     liveness strobe from the supervised logic
//   i_fail_safe     watchdog fail-safe indication (only recorded)
//   i_hardware_rst  watchdog hardware-reset indication
//   o_clrwdt        one-cycle watchdog clear pulse
//   o_state         IDLE=0, ARMED=1, STARVED=2, RESET_HOLD=3
//   o_starved       high while in STARVED
//   o_fail_seen     sticky record of i_fail_safe since reset
//   o_kick_count    number of kicks issued, wraps
//   o_rst_count     number of hardware resets observed, saturates
// -----------------------------------------------------------------------------
module wdt_servicer #(
    parameter int CNT_W     = 32,
    parameter int RST_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [CNT_W-1:0]     i_kick_period,
    input  logic                 i_heartbeat,
    input  logic                 i_fail_safe,
    input  logic                 i_hardware_rst,
    output logic                 o_clrwdt,
    output logic [1:0]           o_state,
    output logic                 o_starved,
    output logic                 o_fail_seen,
    output logic [CNT_W-1:0]     o_kick_count,
    output logic [RST_CNT_W-1:0] o_rst_count
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED      = 2'd1,
        ST_STARVED    = 2'd2,
        ST_RESET_HOLD = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   hb_flag_reg, hb_flag_next;
    logic                   clrwdt_reg, clrwdt_next;
    logic                   starved_reg, starved_next;
    logic                   fail_seen_reg, fail_seen_next;
    logic [CNT_W-1:0]       kick_count_reg, kick_count_next;
    logic [RST_CNT_W-1:0]   rst_count_reg, rst_count_next;

    // One-cycle decisions produced by the state logic.
    logic                   kick;
    logic                   rst_event;

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            hb_flag_reg    <= 1'b0;
            clrwdt_reg     <= 1'b0;
            starved_reg    <= 1'b0;
            fail_seen_reg  <= 1'b0;
            kick_count_reg <= '0;
            rst_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hb_flag_reg    <= hb_flag_next;
            clrwdt_reg     <= clrwdt_next;
            starved_reg    <= starved_next;
            fail_seen_reg  <= fail_seen_next;
            kick_count_reg <= kick_count_next;
            rst_count_reg  <= rst_count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // The watchdog's hardware reset wins over everything, then a dropped
    // enable, then the normal per-state behaviour.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hb_flag_next = hb_flag_reg;
        kick         = 1'b0;
        rst_event    = 1'b0;

        if (i_hardware_rst && (state_reg != ST_RESET_HOLD)) begin
            // A reset is in progress: never kick, forget the current window.
            state_next   = ST_RESET_HOLD;
            cnt_next     = '0;
            hb_flag_next = 1'b0;
            rst_event    = 1'b1;
        end else if (!i_enable && (state_reg != ST_RESET_HOLD)) begin
            // RESET_HOLD deliberately ignores enable so the reset is tracked
            // to its end even if software disables servicing meanwhile.
            state_next   = ST_IDLE;
            cnt_next     = '0;
            hb_flag_next = 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Enable is known high here: issue the initial kick.
                    kick         = 1'b1;
                    cnt_next     = i_kick_period;
                    hb_flag_next = 1'b0;
                    state_next   = ST_ARMED;
                end
                ST_ARMED: begin
                    if (cnt_reg != '0) begin
                        cnt_next     = cnt_reg - CNT_W'(1);
                        hb_flag_next = hb_flag_reg | i_heartbeat;
                    end else if (hb_flag_reg || i_heartbeat) begin
                        // A heartbeat on the expiry edge still counts for
                        // the window that is closing.
                        kick         = 1'b1;
                        cnt_next     = i_kick_period;
                        hb_flag_next = 1'b0;
                    end else begin
                        state_next   = ST_STARVED;
                    end
                end
                ST_STARVED: begin
                    // Sticky until the watchdog resets us or enable drops;
                    // a late heartbeat must not hide the failure.
                    state_next = ST_STARVED;
                end
                ST_RESET_HOLD: begin
                    if (!i_hardware_rst) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output and statistics next values
    // -------------------------------------------------------------------------
    always_comb begin
        clrwdt_next     = kick;
        starved_next    = (state_next == ST_STARVED);
        fail_seen_next  = fail_seen_reg | i_fail_safe;
        kick_count_next = kick ? (kick_count_reg + CNT_W'(1)) : kick_count_reg;
        rst_count_next  = rst_count_reg;
        if (rst_event && (rst_count_reg != {RST_CNT_W{1'b1}})) begin
            rst_count_next = rst_count_reg + RST_CNT_W'(1);
        end
    end

    assign o_clrwdt     = clrwdt_reg;
    assign o_state      = state_reg;
    assign o_starved    = starved_reg;
    assign o_fail_seen  = fail_seen_reg;
    assign o_kick_count = kick_count_reg;
    assign o_rst_count  = rst_count_reg;

endmodule
